// File: rtl/decoders_pkg.sv
// Shared types and helpers for the registered 3-to-8 decoder.
package decoders_pkg;

    localparam int unsigned CODE_W = 3;
    localparam int unsigned OUT_W  = 8;
    localparam int unsigned HCNT_W = 16;

    typedef enum logic {DEC_IDLE, DEC_HOLD} dec_state_t;

    // One-hot expansion of a 3-bit code.
    function automatic logic [OUT_W-1:0] onehot8(input logic [CODE_W-1:0] code);
        logic [OUT_W-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        return one << code;
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter that stops at zero and flags when it is there.
module hold_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    // Count register: clear beats load beats decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/decoders_seq.sv
// Registered 3-to-8 one-hot decoder with valid/ready input and a fixed output hold time.
module decoders_seq
    import decoders_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] binary_in,
    output logic [OUT_W-1:0]  decoder_out,
    output logic              out_valid,
    output logic              busy,
    output logic [CNT_W-1:0]  code_count
);

    localparam logic [HCNT_W-1:0] HoldLoad = HCNT_W'(HOLD_CYCLES - 1);

    dec_state_t       state_q, state_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [CNT_W-1:0] cnt_q;
    logic             hcnt_zero;
    logic             accept;
    logic             tmr_load, tmr_dec, tmr_clear;

    // Ready never looks at in_valid, so there is no loop through the producer.
    assign in_ready = enable && !rst && ((state_q == DEC_IDLE) || hcnt_zero);
    assign accept   = in_valid && in_ready;

    hold_timer #(
        .W (HCNT_W)
    ) u_hold_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (tmr_clear),
        .load     (tmr_load),
        .load_val (HoldLoad),
        .dec      (tmr_dec),
        .zero     (hcnt_zero)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DEC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: leave HOLD on abort or when the final hold cycle passes without a new code.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DEC_IDLE: if (accept) state_d = DEC_HOLD;
            DEC_HOLD: begin
                if (!enable) begin
                    state_d = DEC_IDLE;
                end else if (hcnt_zero && !accept) begin
                    state_d = DEC_IDLE;
                end
            end
            default: state_d = DEC_IDLE;
        endcase
    end

    // Output/control: timer controls and next value of the one-hot register.
    always_comb begin
        tmr_load  = accept;
        tmr_dec   = (state_q == DEC_HOLD);
        tmr_clear = (state_q == DEC_HOLD) && !enable;
        out_d     = out_q;
        if (accept) begin
            out_d = onehot8(binary_in);
        end else if ((state_q == DEC_HOLD) && (!enable || hcnt_zero)) begin
            out_d = '0;
        end
    end

    // Datapath registers: one-hot output and saturating accept counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
            cnt_q <= '0;
        end else begin
            out_q <= out_d;
            if (accept && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign decoder_out = out_q;
    assign out_valid   = |out_q;
    assign busy        = (state_q == DEC_HOLD);
    assign code_count  = cnt_q;

endmodule

// File: tb/tb_decoders_seq.sv
// Self-checking bench: two decoder instances (hold 4 / 8-bit count, hold 1 / 4-bit count)
// compared every cycle against a duration-based behavioural model.
module tb_decoders_seq;

    logic       clk, rst;
    logic       en0, v0, en1, v1;
    logic [2:0] c0, c1;
    logic       rdy0, rdy1, ov0, ov1, busy0, busy1;
    logic [7:0] out0, out1;
    logic [7:0] cnt0;
    logic [3:0] cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: current line, cycles it still has to stay high, accepted-code count.
    int         ml0 = 0, ml1 = 0;
    logic [7:0] mo0 = '0, mo1 = '0;
    int         mc0 = 0, mc1 = 0;

    decoders_seq #(.HOLD_CYCLES(4), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .enable(en0), .in_valid(v0), .in_ready(rdy0),
        .binary_in(c0), .decoder_out(out0), .out_valid(ov0), .busy(busy0),
        .code_count(cnt0)
    );

    decoders_seq #(.HOLD_CYCLES(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .enable(en1), .in_valid(v1), .in_ready(rdy1),
        .binary_in(c1), .decoder_out(out1), .out_valid(ov1), .busy(busy1),
        .code_count(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One clock edge of the model for one instance.
    task automatic step(input int h, input int cmax, input logic en, input logic v,
                        input logic [2:0] c, inout int left, inout logic [7:0] out,
                        inout int cnt);
        logic ready;
        ready = en && (left <= 1);
        if (ready && v) begin
            out  = 8'd1 << c;
            left = h;
            if (cnt < cmax) cnt++;
        end else if (!en) begin
            left = 0;
            out  = '0;
        end else if (left > 0) begin
            left--;
            if (left == 0) out = '0;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ml0 = 0; mo0 = '0; mc0 = 0;
            ml1 = 0; mo1 = '0; mc1 = 0;
        end else begin
            step(4, 255, en0, v0, c0, ml0, mo0, mc0);
            step(1, 15, en1, v1, c1, ml1, mo1, mc1);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("out0",   32'(out0),  32'(mo0));
        chk("valid0", 32'(ov0),   32'(mo0 != 0));
        chk("busy0",  32'(busy0), 32'(ml0 > 0));
        chk("ready0", 32'(rdy0),  32'(en0 && !rst && ml0 <= 1));
        chk("count0", 32'(cnt0),  32'(mc0));
        chk("out1",   32'(out1),  32'(mo1));
        chk("valid1", 32'(ov1),   32'(mo1 != 0));
        chk("busy1",  32'(busy1), 32'(ml1 > 0));
        chk("ready1", 32'(rdy1),  32'(en1 && !rst && ml1 <= 1));
        chk("count1", 32'(cnt1),  32'(mc1));
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        en0 = 0; v0 = 0; c0 = 0; en1 = 0; v1 = 0; c1 = 0;
        rst = 1;
        cyc();
        rst = 0;
    endtask

    initial begin
        rst = 1;
        en0 = 0; v0 = 0; c0 = 0; en1 = 0; v1 = 0; c1 = 0;
        #1;
        chk("rst_out",   32'(out0), 0);
        chk("rst_ready", 32'(rdy0), 0);
        chk("rst_count", 32'(cnt0), 0);
        cyc();
        rst = 0;

        // Basic decode of code 5: 8'h20 for exactly four cycles.
        en0 = 1; v0 = 1; c0 = 3'd5;
        for (int i = 0; i < 4; i++) begin
            cyc();
            v0 = 0;
            chk("basic_out", 32'(out0), 32'h20);
        end
        chk("basic_count", 32'(cnt0), 1);
        cyc();
        chk("basic_clear", 32'(out0), 0);

        // Full sweep with in_valid held: no gap between lines.
        do_reset();
        en0 = 1; v0 = 1; c0 = 3'd0;
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 4; j++) begin
                cyc();
                chk("sweep_out", 32'(out0), 32'(8'd1 << k));
                if (j == 3) begin
                    if (k == 7) v0 = 0;
                    else c0 = 3'(k + 1);
                end
            end
        end
        chk("sweep_count", 32'(cnt0), 8);
        cyc();
        chk("sweep_clear", 32'(out0), 0);

        // Disabled input never accepts.
        do_reset();
        en0 = 0; v0 = 1; c0 = 3'd3;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("dis_ready", 32'(rdy0), 0);
            chk("dis_out",   32'(out0), 0);
        end
        chk("dis_count", 32'(cnt0), 0);

        // Abort by enable in the second hold cycle.
        do_reset();
        en0 = 1; v0 = 1; c0 = 3'd2;
        cyc();
        v0 = 0;
        chk("abort_first", 32'(out0), 32'h04);
        cyc();
        en0 = 0;
        cyc();
        chk("abort_out",   32'(out0),  0);
        chk("abort_busy",  32'(busy0), 0);
        chk("abort_count", 32'(cnt0),  1);

        // Async reset between edges, then accept again.
        do_reset();
        en0 = 1; v0 = 1; c0 = 3'd7;
        cyc();
        v0 = 0;
        chk("arst_before", 32'(out0), 32'h80);
        #1 rst = 1;
        #1;
        chk("arst_out",   32'(out0),  0);
        chk("arst_valid", 32'(ov0),   0);
        chk("arst_busy",  32'(busy0), 0);
        chk("arst_ready", 32'(rdy0),  0);
        chk("arst_count", 32'(cnt0),  0);
        #1 rst = 0;
        v0 = 1; c0 = 3'd1;
        cyc();
        v0 = 0;
        chk("arst_after", 32'(out0), 32'h02);

        // HOLD_CYCLES=1 streaming and 4-bit count saturation.
        do_reset();
        en1 = 1; v1 = 1;
        for (int k = 0; k < 20; k++) begin
            c1 = 3'(k % 8);
            cyc();
            chk("sat_out",   32'(out1), 32'(8'd1 << (k % 8)));
            chk("sat_count", 32'(cnt1), 32'((k + 1 < 15) ? k + 1 : 15));
        end
        v1 = 0;
        cyc();
        chk("sat_clear", 32'(out1), 0);

        // Random traffic on both instances, with occasional mid-cycle reset pulses.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            en0 = ($urandom_range(0, 9) != 0);
            v0  = $urandom_range(0, 1) != 0;
            c0  = 3'($urandom_range(0, 7));
            en1 = ($urandom_range(0, 9) != 0);
            v1  = $urandom_range(0, 1) != 0;
            c1  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) begin
                rst = 1;
                #1 rst = 0;
            end
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decoders_seq.md
# decoders_seq

Registered 3-to-8 one-hot decoder with a valid/ready input handshake and a programmable output hold time. It is the receive-side counterpart of the 8-to-3 `encoders` block: it turns a 3-bit binary code back into a one-hot line. Each accepted code drives its line for a fixed number of cycles, then the block accepts the next code. It sits downstream of the encoder path, or of any producer of 3-bit codes, and drives one-hot strobes to select or indicator logic.

## Interface
Parameters:
- `HOLD_CYCLES`, default 4: cycles each decoded line stays high. Legal range is 1 to 2^16-1.
- `CNT_W`, default 8: width of the accepted-code counter.

Ports:
- `clk`  in  1: single clock. All state changes on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `enable`  in  1: block enable. Low aborts any hold and blocks acceptance.
- `in_valid`  in  1: producer presents a code.
- `in_ready`  out  1: block can accept a code this cycle.
- `binary_in`  in  3: code to decode, 0 to 7.
- `decoder_out`  out  8: registered one-hot output. Bit `binary_in` is set.
- `out_valid`  out  1: high while `decoder_out` is nonzero.
- `busy`  out  1: high in the HOLD state.
- `code_count`  out  CNT_W: saturating count of accepted codes.

## Operation
States: IDLE and HOLD. There is a hold counter `hcnt` of 16 bits.

- **Reset (async):**
  - state = IDLE.
  - `decoder_out` = 0, `out_valid` = 0, `busy` = 0.
  - `hcnt` = 0, `code_count` = 0.
  - `in_ready` = 0 while `rst` is high.
- **Accept:** a code is accepted in a cycle where `in_valid && in_ready`.
- **`in_ready` (combinational):**
  - Equals `enable && (state==IDLE || (state==HOLD && hcnt==0))`.
  - Forced to 0 while `rst` is high.
- **IDLE:**
  - On accept: `decoder_out <= 8'b1 << binary_in`, `out_valid <= 1`, `hcnt <= HOLD_CYCLES-1`, state goes to HOLD.
  - Otherwise outputs stay 0.
- **HOLD:**
  - If `hcnt != 0`: decrement `hcnt` and hold the output.
  - If `hcnt == 0` and an accept occurs: load the new code and reload `hcnt`. State stays HOLD. This is a back-to-back accept with no gap cycle.
  - If `hcnt == 0` and no accept: clear `decoder_out` and `out_valid`, state goes to IDLE.
- **`HOLD_CYCLES` = 1:** `hcnt` loads 0. Every HOLD cycle is therefore a final cycle, and streaming at 1 code per cycle is possible.
- **`enable` low in HOLD:**
  - Next edge: `decoder_out` = 0, `out_valid` = 0, state goes to IDLE.
  - No accept occurs, because `in_ready` is 0.
  - `code_count` is unaffected.
- **`enable` low in IDLE:** no accept. Outputs stay 0.
- **`code_count`:** increments on every accept and saturates at 2^CNT_W-1. It is cleared only by `rst`.
- **`busy`:** equals state==HOLD.
- **One-hot invariant:** `decoder_out` is either 0 or exactly one bit set. `out_valid == |decoder_out`.

## Timing
- **Latency:** a code accepted at edge N appears on `decoder_out` immediately after edge N. The output is registered.
- **Duration:** the line stays high for exactly HOLD_CYCLES cycles, from after edge N through edge N+HOLD_CYCLES.
- **Next accept:** the earliest next accept is at edge N+HOLD_CYCLES. `in_ready` is high in the cycle before that edge.
- **Sustained throughput:** 1 code per HOLD_CYCLES cycles.
- **Handshake rules:**
  - The producer must hold `binary_in` stable while `in_valid` is high and `in_ready` is low.
  - The block never depends on `in_valid` to drive `in_ready`, so there is no combinational loop.
- **Reset mid-hold:** all outputs go to 0 asynchronously, without waiting for a clock edge. The first accept after reset release is possible on the first edge at which `enable && in_valid`.

## Structure
- **Package `decoders_pkg`:**
  - `CODE_W = 3` and `OUT_W = 8`.
  - State enum `dec_state_t {DEC_IDLE, DEC_HOLD}`.
  - Function `onehot8(code)`.
- **Sub-module `hold_timer`:** a loadable down-counter that outputs `zero`. It is instantiated once. Everything else is in `decoders_seq`.

## Test plan
- **Basic decode:** reset, `enable`=1, present `binary_in`=5 with `in_valid`=1 for one cycle. With HOLD_CYCLES=4, expect `decoder_out`=8'h20 and `out_valid`=1 for exactly 4 cycles, then 0. `code_count`=1.
- **Full sweep:** stream codes 0 through 7 with `in_valid` held high. Expect `decoder_out` to go 01, 02, 04, …, 80. Each value lasts 4 cycles with no gap between values. `code_count`=8.
- **Disabled input:** `enable`=0, `in_valid`=1, `binary_in`=3 for 10 cycles. Expect `in_ready`=0, `decoder_out`=0 and `code_count`=0.
- **Abort by `enable`:** accept code 2, then drop `enable` in the 2nd hold cycle. Expect `decoder_out`=0 after the next edge, state IDLE, and `code_count`=1.
- **Async reset mid-hold:** accept code 7, then pulse `rst` between clock edges. Expect all outputs 0 without a clock edge. After release, accept code 1 and expect 8'h02.
- **Saturation and `HOLD_CYCLES`=1:** set CNT_W=4 and HOLD_CYCLES=1, then stream 20 codes. Expect 1 code per cycle on `decoder_out`, and `code_count` to saturate at 15.
